serial_signed_divider: RTL and testbench

//   Iterative signed integer divider; inverse operation to serial_parallel_multiplier.

---
 rtl/spm_pkg.sv | 14 +
 rtl/serial_signed_divider_if.sv | 31 +++
 rtl/sgn_mag.sv | 19 +
 rtl/serial_signed_divider.sv | 182 ++++++++++++++++++
 tb/tb_serial_signed_divider.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/spm_pkg.sv
// spm_pkg: definitions shared by the serial multiplier / divider pair.
//   SPM_WIDTH : default operand width common to both datapaths
//   state_e   : controller states, 2-bit encoding (IDLE, CALC, FIX)
package spm_pkg;

  localparam int SPM_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_signed_divider_if.sv
// serial_signed_divider_if: start/done handshake, operands and results of the
// serial signed divider.
//   master : requester side (drives start/dividend/divisor, reads results)
//   slave  : divider side
interface serial_signed_divider_if
  import spm_pkg::*;
#(
  parameter int WIDTH = SPM_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;
  logic             ovf;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, done, busy, div_by_zero, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, done, busy, div_by_zero, ovf
  );

endinterface

// File: rtl/sgn_mag.sv
// sgn_mag: combinational conditional two's-complement negate.
//   value_i  : WIDTH-bit input
//   neg_i    : 1 -> output the negation of value_i, 0 -> pass through
//   result_o : WIDTH-bit result
// Feeding neg_i with the sign bit of value_i gives the absolute value; the
// result is read as unsigned, so the most negative value maps to 2^(WIDTH-1).
module sgn_mag
  import spm_pkg::*;
#(
  parameter int WIDTH = SPM_WIDTH
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] result_o
);

  assign result_o = neg_i ? (~value_i + WIDTH'(1)) : value_i;

endmodule

// File: rtl/serial_signed_divider.sv
// serial_signed_divider: iterative signed divider, restoring division on the
// operand magnitudes, one quotient bit per clock, sign fix-up at the end.
// Quotient truncates toward zero; remainder takes the sign of the dividend.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset (aborts any operation)
//   bus : slave side of serial_signed_divider_if
//         start/dividend/divisor in; quotient/remainder/done/busy/
//         div_by_zero/ovf out
module serial_signed_divider
  import spm_pkg::*;
#(
  parameter int WIDTH = SPM_WIDTH
) (
  input logic                  clk,
  input logic                  rst,
  serial_signed_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder magnitude
  logic [WIDTH-1:0] quo_q, quo_d;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;      // divisor magnitude
  logic [CW-1:0]    count_q, count_d;
  logic             sgn_dvd_q, sgn_dvd_d;
  logic             sgn_dvs_q, sgn_dvs_d;
  logic             dz_q, dz_d;        // current operation is a divide by zero

  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] abs_dividend, abs_divisor;
  logic [WIDTH-1:0] fix_quo, fix_rem;
  logic [WIDTH:0]   shifted, trial;

  sgn_mag #(.WIDTH(WIDTH)) u_abs_dividend (
    .value_i  (bus.dividend),
    .neg_i    (bus.dividend[WIDTH-1]),
    .result_o (abs_dividend)
  );

  sgn_mag #(.WIDTH(WIDTH)) u_abs_divisor (
    .value_i  (bus.divisor),
    .neg_i    (bus.divisor[WIDTH-1]),
    .result_o (abs_divisor)
  );

  sgn_mag #(.WIDTH(WIDTH)) u_fix_quo (
    .value_i  (quo_q),
    .neg_i    (sgn_dvd_q ^ sgn_dvs_q),
    .result_o (fix_quo)
  );

  // For a divide by zero rem_q holds |dividend|, so this path returns the
  // original dividend as the remainder without a separate mux.
  sgn_mag #(.WIDTH(WIDTH)) u_fix_rem (
    .value_i  (rem_q),
    .neg_i    (sgn_dvd_q),
    .result_o (fix_rem)
  );

  // One extra bit so the borrow of the trial subtract is visible.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    count_d     = count_q;
    sgn_dvd_d   = sgn_dvd_q;
    sgn_dvs_d   = sgn_dvs_q;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;
    busy_d      = busy_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sgn_dvd_d = bus.dividend[WIDTH-1];
          sgn_dvs_d = bus.divisor[WIDTH-1];
          dvs_d     = abs_divisor;
          count_d   = '0;
          busy_d    = 1'b1;
          if (bus.divisor == '0) begin
            dz_d    = 1'b1;
            rem_d   = abs_dividend;
            quo_d   = '0;
            state_d = FIX;
          end else begin
            dz_d    = 1'b0;
            rem_d   = '0;
            quo_d   = abs_dividend;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        quotient_d  = dz_q ? '1 : fix_quo;
        remainder_d = fix_rem;
        dbz_d       = dz_q;
        // A magnitude of 2^(WIDTH-1) with a positive sign only arises from MIN / -1.
        ovf_d       = !dz_q && (quo_q == MIN_MAG) && !(sgn_dvd_q ^ sgn_dvs_q);
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      count_q     <= '0;
      sgn_dvd_q   <= 1'b0;
      sgn_dvs_q   <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      count_q     <= count_d;
      sgn_dvd_q   <= sgn_dvd_d;
      sgn_dvs_q   <= sgn_dvs_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.ovf         = ovf_q;

endmodule

// File: tb/tb_serial_signed_divider.sv
// tb_serial_signed_divider: directed + random checks of serial_signed_divider.
// Expected results are pushed to a scoreboard queue when an operation is
// started and popped by a monitor when done pulses.
module tb_serial_signed_divider;
  import spm_pkg::*;

  localparam int W = SPM_WIDTH;
  localparam int NRAND = 1500;

  typedef struct {
    int              d;
    int              v;
    logic [W-1:0]    q;
    logic [W-1:0]    r;
    logic            dz;
    logic            ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_signed_divider_if #(.WIDTH(W)) bus ();

  serial_signed_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   acc_cyc    = 0;
  int   txn        = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input int d, input int v);
    exp_t e;
    int   dd, vv;
    logic [W-1:0] dw, vw;
    dw = W'(d);
    vw = W'(v);
    dd = $signed(dw);
    vv = $signed(vw);
    e.d = dd;
    e.v = vv;
    if (vv == 0) begin
      e.q = '1; e.r = dw; e.dz = 1'b1; e.ovf = 1'b0;
    end else if (dd == -(2 ** (W - 1)) && vv == -1) begin
      e.q = dw; e.r = '0; e.dz = 1'b0; e.ovf = 1'b1;
    end else begin
      e.q = W'(dd / vv); e.r = W'(dd % vv); e.dz = 1'b0; e.ovf = 1'b0;
    end
    return e;
  endfunction

  // Monitor: compare every done pulse against the scoreboard head.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        txn++;
        $display("txn %0d: %0d / %0d -> q=%0d r=%0d dbz=%0b ovf=%0b", txn, mon_e.d, mon_e.v,
                 $signed(bus.quotient), $signed(bus.remainder), bus.div_by_zero, bus.ovf);
        chk("quotient", bus.quotient, mon_e.q);
        chk("remainder", bus.remainder, mon_e.r);
        chk("div_by_zero", bus.div_by_zero, mon_e.dz);
        chk("ovf", bus.ovf, mon_e.ovf);
        chk("busy_at_done", bus.busy, 1'b0);
      end
    end
  end

  // Drive one request; E0 is the following rising edge.
  task automatic start_op(input int d, input int v, input bit push);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = W'(d);
    bus.divisor  = W'(v);
    if (push) sb.push_back(model(d, v));
    @(posedge clk);
    #1;
    acc_cyc      = cyc;
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
    chk("busy_after_accept", bus.busy, 1'b1);
  endtask

  // Latency counts the accepting edge as edge 1.
  task automatic wait_done(input int exp_lat);
    while (bus.done !== 1'b1 && (cyc - acc_cyc) < 40) begin
      @(posedge clk);
      #1;
    end
    chk("latency", cyc - acc_cyc + 1, exp_lat);
  endtask

  task automatic op(input int d, input int v);
    start_op(d, v, 1'b1);
    wait_done((W'(v) == '0) ? 2 : W + 2);
  endtask

  initial begin
    int n_done;
    int rd, rv;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_quotient", bus.quotient, '0);
    chk("rst_remainder", bus.remainder, '0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_dbz", bus.div_by_zero, 1'b0);
    chk("rst_ovf", bus.ovf, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    op(100, 7);
    chk("q_100_7", bus.quotient, 8'd14);
    chk("r_100_7", bus.remainder, 8'd2);
    op(-100, 7);
    op(100, -7);
    op(-100, -7);
    chk("q_m100_m7", bus.quotient, 8'd14);
    chk("r_m100_m7", bus.remainder, 8'hFE);
    op(-128, -1);
    chk("ovf_min_m1", bus.ovf, 1'b1);
    op(-128, 1);
    op(5, 0);
    chk("q_5_0", bus.quotient, 8'hFF);
    op(6, 3);
    chk("dbz_cleared", bus.div_by_zero, 1'b0);

    // Second request while busy is ignored.
    start_op(50, 5, 1'b1);
    repeat (3) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd9;
    bus.divisor  = 8'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(W + 2);
    chk("q_50_5", bus.quotient, 8'd10);
    // Back-to-back start in the done cycle.
    op(12, -4);

    // Abort mid-operation.
    start_op(77, 3, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_quotient", bus.quotient, '0);
    chk("abort_remainder", bus.remainder, '0);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
    end
    chk("no_done_after_abort", n_done, 0);
    op(77, 3);
    chk("q_77_3", bus.quotient, 8'd25);
    chk("r_77_3", bus.remainder, 8'd2);

    // Boundary pairs.
    op(0, 5);   op(0, -1);    op(127, 1);    op(-128, 127);
    op(127, -128); op(-128, -128); op(-1, -128); op(7, 7);
    op(-128, 0); op(127, 0);   op(-7, 2);     op(1, -1);

    for (int i = 0; i < NRAND; i++) begin
      rd = int'($urandom_range(0, 255));
      rv = int'($urandom_range(0, 255));
      if (i % 50 == 0) rv = 0;
      if (i % 50 == 1) rv = 1;
      op(rd, rv);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation timed out");
  end

endmodule
